uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter; the send-side counterpart of the team's uart_rx, using the same frame: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high), no parity.
- Serializes bytes from the bubble-sort FSM result path onto the serial line.
- Adds a one-byte holding register so the sender can queue the next byte while a frame is on the wire. Queued frames go out back-to-back with no idle gap.

Parameters:
- CLKS_PER_BIT, 57, i_clock cycles per serial bit. Legal range is 2..256. Same value as the paired uart_rx.

Ports:
- i_clock  input  1  system clock. All logic is on the rising edge.
- i_reset  input  1  reset, synchronous and active-high.
- i_Tx_DV  input  1  byte-valid strobe. Sampled on each rising edge.
- i_Tx_Byte  input  8  byte to send. Captured only when i_Tx_DV is high and o_Tx_Ready is high.
- o_Tx_Ready  output  1  high while the holding register is empty, meaning a byte can be accepted.
- o_Tx_Active  output  1  high while a frame (start, data or stop bit) is being driven.
- o_Tx_Serial  output  1  serial line. Idle level is 1.
- o_Tx_Done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Registered state:
  - FSM state
  - bit-period counter, width ceil(log2(CLKS_PER_BIT))
  - 3-bit bit index
  - 8-bit shift register
  - 8-bit holding register plus a hold_full flag
  - all four outputs, each driven from a register
- Reset, effective at the first edge with i_reset=1:
  - o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1
  - state=IDLE, counter=0, index=0, hold_full=0
  - Reset overrides every other action, including during a frame. The line returns high at that edge, any queued byte is discarded, and no Done pulse is produced.
- Acceptance:
  - A byte is accepted at any edge where i_Tx_DV=1 and o_Tx_Ready=1.
  - If i_Tx_DV=1 while o_Tx_Ready=0, the byte is dropped silently and state is unchanged.
- FSM states:
  - IDLE:
    - Line is high and Active=0.
    - If a byte is accepted at this edge, or hold_full=1, load the shifter and enter START at this edge. o_Tx_Serial=0 and Active=1 from the next cycle.
    - An accepted byte in IDLE with the holding register empty bypasses the holding register, so Ready stays 1.
  - START:
    - Drive 0 for exactly CLKS_PER_BIT cycles, then go to DATA with counter=0 and index=0.
  - DATA:
    - Drive shifter[index] for CLKS_PER_BIT cycles per bit.
    - After the last cycle of bit 7, go to STOP.
    - Each bit value is stable for its whole period.
  - STOP:
    - Drive 1 for CLKS_PER_BIT cycles.
    - At the edge ending the stop bit, pulse o_Tx_Done=1 for one cycle.
    - If hold_full=1 at that edge: move the holding register into the shifter, clear hold_full (Ready=1 next cycle), and enter START directly. The next start bit begins on the very next cycle.
    - Otherwise enter CLEANUP and set Active=0.
  - CLEANUP:
    - One cycle with the line high, then IDLE.
    - A byte accepted in this cycle goes into the holding register. IDLE then starts it at the next edge.
- Holding register:
  - Accepts a byte whenever hold_full=0, in any state other than IDLE's direct-load case.
  - Sets hold_full, which drives Ready=0 from the next cycle.
- Timing:
  - From an accepting edge in IDLE to the first stop-bit completion is 10*CLKS_PER_BIT cycles.
  - Back-to-back frames are exactly 10*CLKS_PER_BIT cycles apart.
- Same-edge events:
  - If i_Tx_DV=1 coincides with the hold being drained at stop-bit end, the new byte is not accepted, because Ready was 0 in that cycle.
- Counter compares against CLKS_PER_BIT-1. There must be no off-by-one: each bit is exactly CLKS_PER_BIT cycles, checked on o_Tx_Serial.
- Loopback: o_Tx_Serial fed into a uart_rx with the same CLKS_PER_BIT reproduces every byte.

Test Plan:
- Single frame, CLKS_PER_BIT=4, send 0xA5 from IDLE:
  - o_Tx_Serial reads 0, 1,0,1,0,0,1,0,1, 1, with each level lasting 4 cycles.
  - Done pulses once, 40 cycles after acceptance.
  - Active falls the following cycle.
- Queued pair, CLKS_PER_BIT=4, send 0x3C then 0xFF during the first frame's data bits:
  - Ready falls after the second accept and rises at the first Done.
  - The second start bit immediately follows the first stop bit.
  - Two Done pulses 40 cycles apart.
- Overflow, CLKS_PER_BIT=4: with the hold full, strobe 0x11:
  - The strobe is ignored.
  - Only the first two bytes appear on the line.
  - Exactly two Done pulses.
- Reset mid-frame: assert i_reset during data bit 3 of 0x55, with 0x66 queued:
  - Serial=1, Active=0, Ready=1 at the next cycle.
  - No Done pulse, and 0x66 is never sent.
- Loopback with uart_rx at CLKS_PER_BIT=57: send 0x00, 0xFF, 0x5A, 0x81:
  - Receiver o_Rx_byte matches on each o_Rx_DV, in order.
- Cleanup-cycle accept: strobe 0x42 exactly in the CLEANUP cycle:
  - The byte is captured.
  - Its start bit begins 2 cycles after the previous Done.

Source files
------------

// File: rtl/uart_tx_if.sv
// Byte-in / serial-out handshake of the UART transmitter.
// Master is the byte producer; slave is the transmitter.
interface uart_tx_if;
    logic       i_Tx_DV;
    logic [7:0] i_Tx_Byte;
    logic       o_Tx_Ready;
    logic       o_Tx_Active;
    logic       o_Tx_Serial;
    logic       o_Tx_Done;

    modport master (
        output i_Tx_DV,
        output i_Tx_Byte,
        input  o_Tx_Ready,
        input  o_Tx_Active,
        input  o_Tx_Serial,
        input  o_Tx_Done
    );

    modport slave (
        input  i_Tx_DV,
        input  i_Tx_Byte,
        output o_Tx_Ready,
        output o_Tx_Active,
        output o_Tx_Serial,
        output o_Tx_Done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, with a one-byte holding register so that
// queued frames leave back-to-back without an idle gap.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 57
) (
    input logic      i_clock,
    input logic      i_reset,
    uart_tx_if.slave tx
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StCleanup
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      hold_q;
    logic            hold_full_q;
    logic            ready_q;
    logic            active_q;
    logic            serial_q;
    logic            done_q;

    logic accept;
    logic direct_load;
    logic hold_load;
    logic bit_end;

    always_comb begin
        accept      = tx.i_Tx_DV & ready_q;
        // An idle transmitter with an empty hold starts the byte straight away.
        direct_load = accept & (state_q == StIdle) & ~hold_full_q;
        hold_load   = accept & ~direct_load;
        bit_end     = (cnt_q == CntLast);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            active_q    <= 1'b0;
            serial_q    <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (hold_load) begin
                hold_q      <= tx.i_Tx_Byte;
                hold_full_q <= 1'b1;
                ready_q     <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    serial_q <= 1'b1;
                    active_q <= 1'b0;
                    if (direct_load || hold_full_q) begin
                        shift_q  <= hold_full_q ? hold_q : tx.i_Tx_Byte;
                        state_q  <= StStart;
                        serial_q <= 1'b0;
                        active_q <= 1'b1;
                        cnt_q    <= '0;
                        idx_q    <= '0;
                        if (hold_full_q) begin
                            hold_full_q <= 1'b0;
                            ready_q     <= 1'b1;
                        end
                    end
                end

                StStart: begin
                    if (bit_end) begin
                        cnt_q    <= '0;
                        idx_q    <= '0;
                        state_q  <= StData;
                        serial_q <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end

                StData: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd7) begin
                            state_q  <= StStop;
                            serial_q <= 1'b1;
                        end else begin
                            idx_q    <= idx_q + 3'd1;
                            serial_q <= shift_q[idx_q + 3'd1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end

                StStop: begin
                    if (bit_end) begin
                        cnt_q  <= '0;
                        done_q <= 1'b1;
                        if (hold_full_q) begin
                            // Drain the hold into the next frame with no idle cycle.
                            shift_q     <= hold_q;
                            hold_full_q <= 1'b0;
                            ready_q     <= 1'b1;
                            idx_q       <= '0;
                            state_q     <= StStart;
                            serial_q    <= 1'b0;
                        end else begin
                            state_q  <= StCleanup;
                            active_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end

                StCleanup: begin
                    serial_q <= 1'b1;
                    state_q  <= StIdle;
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx.o_Tx_Ready  = ready_q;
    assign tx.o_Tx_Active = active_q;
    assign tx.o_Tx_Serial = serial_q;
    assign tx.o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a line decoder and a behavioural receiver feed scoreboard
// queues filled by the stimulus; directed timing checks run in the main thread.
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4;
    logic rst57;

    uart_tx_if if4 ();
    uart_tx_if if57 ();

    uart_tx #(.CLKS_PER_BIT(4)) u_dut4 (
        .i_clock (clk),
        .i_reset (rst4),
        .tx      (if4)
    );

    uart_tx #(.CLKS_PER_BIT(57)) u_dut57 (
        .i_clock (clk),
        .i_reset (rst57),
        .tx      (if57)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt4 = 0;
    int last_end4 = -100;
    int rx_cnt57 = 0;
    logic [7:0] q4[$];
    logic [7:0] q57[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Call just after a negedge; returns at the negedge after the sampling edge.
    task automatic send(input int sel, input logic [7:0] b, output int acc);
        if (sel == 4) begin
            if4.i_Tx_DV = 1'b1; if4.i_Tx_Byte = b;
        end else begin
            if57.i_Tx_DV = 1'b1; if57.i_Tx_Byte = b;
        end
        @(negedge clk);
        acc = cyc;
        if4.i_Tx_DV = 1'b0;
        if57.i_Tx_DV = 1'b0;
    endtask

    task automatic wait_done4(input int limit, output int c);
        c = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (if4.o_Tx_Done === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no pulse, expected one within %0d cycles", limit);
        end
    endtask

    // Frame decoder for the CLKS_PER_BIT=4 instance: every level must last 4 samples.
    initial begin : dec4
        logic [7:0] b;
        bit ok;
        bit ab;
        forever begin
            @(negedge clk);
            if (!rst4 && if4.o_Tx_Serial === 1'b0) begin
                ok = 1; ab = 0; b = '0;
                for (int s = 1; s < 40; s++) begin
                    @(negedge clk);
                    if (rst4) begin
                        ab = 1;
                        break;
                    end
                    if (s < 4) begin
                        if (if4.o_Tx_Serial !== 1'b0) ok = 0;
                    end else if (s < 36) begin
                        if (((s - 4) % 4) == 0) b[(s - 4) / 4] = if4.o_Tx_Serial;
                        else if (if4.o_Tx_Serial !== b[(s - 4) / 4]) ok = 0;
                    end else begin
                        if (if4.o_Tx_Serial !== 1'b1) ok = 0;
                    end
                end
                if (!ab) begin
                    last_end4 = cyc;
                    chk("frame_bit_timing", 32'(ok), 32'd1);
                    if (q4.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got byte %0d, expected no frame", b);
                    end else begin
                        chk("frame_byte", 32'(b), 32'(q4.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : mon_done4
        forever begin
            @(negedge clk);
            if (if4.o_Tx_Done === 1'b1) begin
                done_cnt4++;
                chk("done_after_stop", cyc, last_end4 + 1);
            end
        end
    end

    // Behavioural receiver for the loopback instance, mid-bit sampling.
    initial begin : rx57
        logic [7:0] rb;
        bit fok;
        forever begin
            @(negedge clk);
            if (!rst57 && if57.o_Tx_Serial === 1'b0) begin
                repeat (28) @(negedge clk);
                fok = (if57.o_Tx_Serial === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (57) @(negedge clk);
                    rb[i] = if57.o_Tx_Serial;
                end
                repeat (57) @(negedge clk);
                if (if57.o_Tx_Serial !== 1'b1) fok = 0;
                rx_cnt57++;
                chk("loop_framing", 32'(fok), 32'd1);
                if (q57.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL loop_unexpected: got byte %0d, expected no frame", rb);
                end else begin
                    chk("loop_byte", 32'(rb), 32'(q57.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, expected finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int acc, t, d1, d2, n;
        logic [7:0] lb [4];
        lb = '{8'h00, 8'hFF, 8'h5A, 8'h81};

        rst4 = 1'b1; rst57 = 1'b1;
        if4.i_Tx_DV = 1'b0; if4.i_Tx_Byte = '0;
        if57.i_Tx_DV = 1'b0; if57.i_Tx_Byte = '0;
        repeat (3) @(negedge clk);
        chk("rst_serial", 32'(if4.o_Tx_Serial), 32'd1);
        chk("rst_active", 32'(if4.o_Tx_Active), 32'd0);
        chk("rst_ready", 32'(if4.o_Tx_Ready), 32'd1);
        chk("rst_done", 32'(if4.o_Tx_Done), 32'd0);
        rst4 = 1'b0; rst57 = 1'b0;
        @(negedge clk);

        // Single frame 0xA5.
        q4.push_back(8'hA5);
        send(4, 8'hA5, acc);
        chk("bypass_ready", 32'(if4.o_Tx_Ready), 32'd1);
        chk("first_start_low", 32'(if4.o_Tx_Serial), 32'd0);
        chk("first_active", 32'(if4.o_Tx_Active), 32'd1);
        wait_done4(60, d1);
        chk("a5_latency", d1 - acc, 40);
        @(negedge clk);
        chk("active_fall", 32'(if4.o_Tx_Active), 32'd0);
        repeat (3) @(negedge clk);

        // Queued pair plus an overflow strobe.
        n = done_cnt4;
        q4.push_back(8'h3C);
        send(4, 8'h3C, acc);
        repeat (9) @(negedge clk);
        q4.push_back(8'hFF);
        send(4, 8'hFF, t);
        chk("ready_low_queued", 32'(if4.o_Tx_Ready), 32'd0);
        send(4, 8'h11, t);
        chk("ready_low_overflow", 32'(if4.o_Tx_Ready), 32'd0);
        wait_done4(60, d1);
        chk("pair_first_latency", d1 - acc, 40);
        chk("ready_at_first_done", 32'(if4.o_Tx_Ready), 32'd1);
        chk("back_to_back_start", 32'(if4.o_Tx_Serial), 32'd0);
        wait_done4(60, d2);
        chk("pair_spacing", d2 - d1, 40);
        repeat (60) @(negedge clk);
        chk("pair_done_count", done_cnt4 - n, 2);

        // Byte strobed in the cleanup cycle.
        q4.push_back(8'h20);
        send(4, 8'h20, acc);
        wait_done4(60, d1);
        q4.push_back(8'h42);
        send(4, 8'h42, t);
        chk("cleanup_accept_ready", 32'(if4.o_Tx_Ready), 32'd0);
        chk("cleanup_idle_line", 32'(if4.o_Tx_Serial), 32'd1);
        @(negedge clk);
        chk("cleanup_start_gap", 32'(if4.o_Tx_Serial), 32'd0);
        wait_done4(60, d2);
        chk("cleanup_frame_latency", d2 - d1, 42);
        repeat (3) @(negedge clk);

        // Reset during data bit 3 of 0x55 with 0x66 queued.
        send(4, 8'h55, acc);
        repeat (4) @(negedge clk);
        send(4, 8'h66, t);
        while (cyc < acc + 17) @(negedge clk);
        chk("pre_reset_ready", 32'(if4.o_Tx_Ready), 32'd0);
        n = done_cnt4;
        rst4 = 1'b1;
        @(negedge clk);
        chk("mid_reset_serial", 32'(if4.o_Tx_Serial), 32'd1);
        chk("mid_reset_active", 32'(if4.o_Tx_Active), 32'd0);
        chk("mid_reset_ready", 32'(if4.o_Tx_Ready), 32'd1);
        @(negedge clk);
        rst4 = 1'b0;
        repeat (120) @(negedge clk);
        chk("reset_no_done", done_cnt4 - n, 0);
        chk("reset_line_idle", 32'(if4.o_Tx_Serial), 32'd1);

        // Loopback at CLKS_PER_BIT=57.
        foreach (lb[i]) begin
            for (int k = 0; k < 2000 && if57.o_Tx_Ready !== 1'b1; k++) @(negedge clk);
            q57.push_back(lb[i]);
            send(57, lb[i], t);
        end
        for (int k = 0; k < 4000 && rx_cnt57 < 4; k++) @(negedge clk);
        repeat (100) @(negedge clk);
        chk("loop_rx_count", rx_cnt57, 4);
        chk("loop_queue_drained", q57.size(), 0);
        chk("line_queue_drained", q4.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
